// File: rtl/benes_network_pipe.sv
// ---------------------------------------------------------------------------
// benes_network_pipe
//   Parametrised, fully pipelined N x N rearrangeable Benes permutation
//   network. Each switch column is one register stage; a valid flag and the
//   configuration-epoch id travel with every word. Switch settings are
//   double-buffered: software fills a shadow table row by row, and a commit
//   launches the new table down the pipeline as a wavefront, so every word is
//   routed by exactly one configuration epoch.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_port[k]    input words, DATA_W bits each
//   i_valid      i_port carries a word this cycle
//   o_port[k]    permuted words (hold the last valid word)
//   o_valid      o_port was updated by a word this cycle
//   o_cfg_id     epoch id of the configuration that routed o_port
//   cfg_wr_en    write cfg_data into shadow row cfg_stage
//   cfg_stage    shadow row index (values >= STAGES are ignored)
//   cfg_data     switch bits for that row (1 = cross, 0 = bar)
//   cfg_commit   copy shadow into the active configuration
// ---------------------------------------------------------------------------
module benes_network_pipe #(
  parameter  int N_PORTS      = 16,
  parameter  int DATA_W       = 4,
  parameter  int ID_W         = 4,
  localparam int LOG2N        = $clog2(N_PORTS),
  localparam int STAGES       = 2*LOG2N-1,
  localparam int SW_PER_STAGE = N_PORTS/2,
  localparam int SIDX_W       = $clog2(STAGES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       i_port [N_PORTS],
  input  logic                    i_valid,
  output logic [DATA_W-1:0]       o_port [N_PORTS],
  output logic                    o_valid,
  output logic [ID_W-1:0]         o_cfg_id,
  input  logic                    cfg_wr_en,
  input  logic [SIDX_W-1:0]       cfg_stage,
  input  logic [SW_PER_STAGE-1:0] cfg_data,
  input  logic                    cfg_commit
);

  // Destination of position i when leaving column s for column s+1.
  // First half: inverse shuffle inside blocks of N>>s.
  // Second half: perfect shuffle inside blocks of 2^(s-LOG2N+3).
  function automatic int wire_dest(int s, int i);
    int m;
    int base;
    int p;
    int d;
    if (s < LOG2N-1) begin
      m = N_PORTS >> s;
    end else begin
      m = 1 << (s - LOG2N + 3);
    end
    base = i - (i % m);
    p    = i % m;
    if (s < LOG2N-1) begin
      d = ((p % 2) == 0) ? (p / 2) : (m / 2 + p / 2);
    end else begin
      d = (p < m / 2) ? (2 * p) : (2 * (p - m / 2) + 1);
    end
    return base + d;
  endfunction

  // Configuration state
  logic [SW_PER_STAGE-1:0] r_shadow     [STAGES];
  logic [SW_PER_STAGE-1:0] w_shadow_nxt [STAGES];
  logic [SW_PER_STAGE-1:0] w_act        [STAGES];
  logic [ID_W-1:0]         r_epoch;

  // Datapath state
  logic [DATA_W-1:0] r_data  [STAGES][N_PORTS];
  logic              r_valid [STAGES];
  logic [ID_W-1:0]   r_id    [STAGES];

  logic [DATA_W-1:0] w_in    [STAGES][N_PORTS];
  logic [DATA_W-1:0] w_sw    [STAGES][N_PORTS];
  logic              w_vin   [STAGES];
  logic [ID_W-1:0]   w_idin  [STAGES];

  // Shadow table with same-edge write-through, so a commit in the same cycle
  // as a write picks the written row up.
  always_comb begin
    for (int unsigned r = 0; r < STAGES; r++) begin
      w_shadow_nxt[r] = r_shadow[r];
      if (cfg_wr_en && (32'(cfg_stage) == r)) begin
        w_shadow_nxt[r] = cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < STAGES; r++) begin
        r_shadow[r] <= '0;
      end
      r_epoch <= '0;
    end else begin
      for (int unsigned r = 0; r < STAGES; r++) begin
        r_shadow[r] <= w_shadow_nxt[r];
      end
      if (cfg_commit) begin
        r_epoch <= r_epoch + ID_W'(1);
      end
    end
  end

  // Active configuration wavefront. Conceptually act[s] is a full table copy
  // delayed s cycles behind act[0]; stage s only ever reads row s, so each row
  // keeps just its own delay line of depth r+1 instead of the whole table per
  // stage. Back-to-back commits simply occupy consecutive delay-line slots.
  for (genvar r = 0; r < STAGES; r++) begin : g_row
    logic [SW_PER_STAGE-1:0] r_dl [r+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < r + 1; k++) begin
          r_dl[k] <= '0;
        end
      end else begin
        if (cfg_commit) begin
          r_dl[0] <= w_shadow_nxt[r];
        end
        for (int unsigned k = 1; k < r + 1; k++) begin
          r_dl[k] <= r_dl[k-1];
        end
      end
    end

    assign w_act[r] = r_dl[r];
  end

  // Column inputs: stage 0 takes the ports, later stages take the wired
  // outputs of the previous column's registers.
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        w_in[s][k] = '0;
      end
    end
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      w_in[0][k] = i_port[k];
    end
    for (int unsigned s = 1; s < STAGES; s++) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        w_in[s][wire_dest(int'(s) - 1, int'(i))] = r_data[s-1][i];
      end
    end
  end

  // 2x2 switches: bit j set crosses positions 2j and 2j+1.
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      for (int unsigned j = 0; j < SW_PER_STAGE; j++) begin
        if (w_act[s][j]) begin
          w_sw[s][2*j]   = w_in[s][2*j+1];
          w_sw[s][2*j+1] = w_in[s][2*j];
        end else begin
          w_sw[s][2*j]   = w_in[s][2*j];
          w_sw[s][2*j+1] = w_in[s][2*j+1];
        end
      end
    end
  end

  // Valid and epoch id enter with the word at stage 0 and ride along.
  always_comb begin
    w_vin[0]  = i_valid;
    w_idin[0] = r_epoch;
    for (int unsigned s = 1; s < STAGES; s++) begin
      w_vin[s]  = r_valid[s-1];
      w_idin[s] = r_id[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_id[s]    <= '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
          r_data[s][k] <= '0;
        end
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_valid[s] <= w_vin[s];
        if (w_vin[s]) begin
          r_id[s] <= w_idin[s];
          for (int unsigned k = 0; k < N_PORTS; k++) begin
            r_data[s][k] <= w_sw[s][k];
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      o_port[k] = r_data[STAGES-1][k];
    end
  end

  assign o_valid  = r_valid[STAGES-1];
  assign o_cfg_id = r_id[STAGES-1];

endmodule

// File: tb/tb_benes_network_pipe.sv
// ---------------------------------------------------------------------------
// tb_benes_network_pipe
//   Self-checking bench for benes_network_pipe (16 ports, 4-bit words).
//   The reference tracks where each input position lands by walking it
//   through the switch columns, and applies a whole configuration epoch to a
//   word at the moment it is sampled.
// ---------------------------------------------------------------------------
module tb_benes_network_pipe;

  localparam int N      = 16;
  localparam int DW     = 4;
  localparam int IDW    = 4;
  localparam int LOG2N  = 4;
  localparam int STAGES = 7;
  localparam int SW     = 8;
  localparam int SIDX_W = 3;
  localparam int RING   = 16;

  typedef logic [DW-1:0] vec_t [N];
  typedef logic [SW-1:0] cfg_t [STAGES];

  logic            clk = 1'b0;
  logic            rst_n;
  vec_t            i_port;
  logic            i_valid;
  vec_t            o_port;
  logic            o_valid;
  logic [IDW-1:0]  o_cfg_id;
  logic            cfg_wr_en;
  logic [SIDX_W-1:0] cfg_stage;
  logic [SW-1:0]   cfg_data;
  logic            cfg_commit;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  benes_network_pipe #(
    .N_PORTS (N),
    .DATA_W  (DW),
    .ID_W    (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_port     (i_port),
    .i_valid    (i_valid),
    .o_port     (o_port),
    .o_valid    (o_valid),
    .o_cfg_id   (o_cfg_id),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_stage  (cfg_stage),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  function automatic logic [63:0] pack(vec_t v);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = v[k];
    return r;
  endfunction

  // Position of a word lane after the wiring that follows column s.
  function automatic int wire_pos(int s, int pos);
    int m;
    int p;
    int base;
    if (s < LOG2N - 1) begin
      m = N >> s;
      base = (pos / m) * m;
      p = pos % m;
      return base + (((p % 2) == 0) ? p / 2 : m / 2 + p / 2);
    end
    m = 1 << (s - LOG2N + 3);
    base = (pos / m) * m;
    p = pos % m;
    return base + ((p < m / 2) ? 2 * p : 2 * (p - m / 2) + 1);
  endfunction

  // Follow every input lane through the network and drop its word where it lands.
  function automatic void model_route(input cfg_t cfg, input vec_t win, output vec_t wout);
    int pos;
    for (int k = 0; k < N; k++) begin
      pos = k;
      for (int s = 0; s < STAGES; s++) begin
        if (cfg[s][pos / 2]) pos = pos ^ 1;
        if (s < STAGES - 1) pos = wire_pos(s, pos);
      end
      wout[pos] = win[k];
    end
  endfunction

  // ---------------- reference model ----------------
  cfg_t           m_shadow;
  cfg_t           m_cfg;
  logic [IDW-1:0] m_epoch = '0;
  vec_t           m_out;
  logic           m_oval = 1'b0;
  logic [IDW-1:0] m_id = '0;
  vec_t           ring_d [RING];
  bit             ring_v [RING];
  logic [IDW-1:0] ring_id [RING];
  vec_t           m_tmp;
  int             cyc = 0;
  int             m_slot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < STAGES; r++) begin
        m_shadow[r] = '0;
        m_cfg[r]    = '0;
      end
      for (int k = 0; k < N; k++) m_out[k] = '0;
      for (int i = 0; i < RING; i++) ring_v[i] = 1'b0;
      m_epoch = '0;
      m_oval  = 1'b0;
      m_id    = '0;
      cyc     = 0;
    end else begin
      if (i_valid) begin
        model_route(m_cfg, i_port, m_tmp);
        m_slot = (cyc + STAGES - 1) % RING;
        ring_d[m_slot]  = m_tmp;
        ring_v[m_slot]  = 1'b1;
        ring_id[m_slot] = m_epoch;
      end
      if (cfg_wr_en && (int'(cfg_stage) < STAGES)) m_shadow[cfg_stage] = cfg_data;
      if (cfg_commit) begin
        m_cfg   = m_shadow;
        m_epoch = m_epoch + 1'b1;
      end
      m_slot = cyc % RING;
      if (ring_v[m_slot]) begin
        m_out  = ring_d[m_slot];
        m_id   = ring_id[m_slot];
        m_oval = 1'b1;
        ring_v[m_slot] = 1'b0;
      end else begin
        m_oval = 1'b0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model o_valid", 64'(o_valid), 64'(m_oval));
      chk("model o_cfg_id", 64'(o_cfg_id), 64'(m_id));
      chk("model o_port", pack(o_port), pack(m_out));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(int r, logic [SW-1:0] d);
    cfg_wr_en = 1'b1;
    cfg_stage = SIDX_W'(r);
    cfg_data  = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic send(vec_t w);
    i_port  = w;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic check_out(string nm, vec_t e, int id);
    chk({nm, " valid"}, 64'(o_valid), 64'd1);
    chk({nm, " port"}, pack(o_port), pack(e));
    chk({nm, " id"}, 64'(o_cfg_id), 64'(id));
  endtask

  vec_t w;
  vec_t e;
  vec_t r_m;
  cfg_t c;

  initial begin
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    cfg_wr_en  = 1'b0;
    cfg_stage  = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    for (int k = 0; k < N; k++) i_port[k] = '0;

    // Pin the reference against hand-derived permutations.
    for (int k = 0; k < N; k++) w[k] = DW'(k);
    for (int r = 0; r < STAGES; r++) c[r] = '0;
    model_route(c, w, r_m);
    chk("pin identity", pack(r_m), 64'hFEDCBA9876543210);
    for (int r = 0; r < STAGES; r++) c[r] = 8'hFF;
    model_route(c, w, r_m);
    chk("pin all-cross", pack(r_m), 64'h76543210FEDCBA98);
    for (int r = 0; r < STAGES; r++) c[r] = (r == 3) ? 8'hFF : 8'h00;
    model_route(c, w, r_m);
    chk("pin row3", pack(r_m), 64'h76543210FEDCBA98);
    for (int r = 0; r < STAGES; r++) c[r] = (r == 6) ? 8'h01 : 8'h00;
    model_route(c, w, r_m);
    chk("pin row6", pack(r_m), 64'hFEDCBA9876543201);
    for (int r = 0; r < STAGES; r++) c[r] = (r == 0) ? 8'h01 : 8'h00;
    model_route(c, w, r_m);
    chk("pin row0", pack(r_m), 64'hFEDCBA9876543201);

    repeat (3) tick();
    chk("reset o_valid", 64'(o_valid), 64'd0);
    chk("reset o_port", pack(o_port), 64'd0);
    chk("reset o_cfg_id", 64'(o_cfg_id), 64'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Single word through identity: latency and hold.
    for (int k = 0; k < N; k++) w[k] = DW'(15 - k);
    send(w);
    repeat (6) tick();
    check_out("identity", w, 0);
    tick();
    chk("pulse o_valid", 64'(o_valid), 64'd0);
    chk("hold o_port", pack(o_port), pack(w));

    // All-cross.
    for (int r = 0; r < STAGES; r++) cfg_write(r, 8'hFF);
    commit();
    for (int k = 0; k < N; k++) begin w[k] = DW'(k); e[k] = DW'(k ^ 8); end
    send(w);
    repeat (6) tick();
    check_out("all-cross", e, 1);

    // Only middle column crossed.
    for (int r = 0; r < STAGES; r++) cfg_write(r, (r == 3) ? 8'hFF : 8'h00);
    commit();
    for (int k = 0; k < N; k++) w[k] = DW'($urandom);
    for (int k = 0; k < N; k++) e[k] = w[k ^ 8];
    send(w);
    repeat (6) tick();
    check_out("row3", e, 2);

    // Only last column, switch 0.
    for (int r = 0; r < STAGES; r++) cfg_write(r, (r == 6) ? 8'h01 : 8'h00);
    commit();
    for (int k = 0; k < N; k++) w[k] = DW'($urandom);
    e = w; e[0] = w[1]; e[1] = w[0];
    send(w);
    repeat (6) tick();
    check_out("row6", e, 3);

    // Streaming across a commit.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < STAGES; r++) cfg_write(r, 8'hFF);
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          for (int k = 0; k < N; k++) i_port[k] = DW'(k + n);
          i_valid    = 1'b1;
          cfg_commit = (n == 5);
          tick();
        end
        i_valid    = 1'b0;
        cfg_commit = 1'b0;
      end
      begin
        vec_t se;
        repeat (7) tick();
        for (int n = 0; n < 12; n++) begin
          for (int k = 0; k < N; k++) se[k] = (n <= 5) ? DW'(k + n) : DW'((k ^ 8) + n);
          check_out($sformatf("stream word %0d", n), se, (n <= 5) ? 0 : 1);
          tick();
        end
      end
    join

    // Reset while words are in flight.
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < N; k++) i_port[k] = DW'($urandom);
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset o_valid", 64'(o_valid), 64'd0);
    chk("midreset o_port", pack(o_port), 64'd0);
    chk("midreset o_cfg_id", 64'(o_cfg_id), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      chk("post-reset quiet", 64'(o_valid), 64'd0);
    end
    for (int k = 0; k < N; k++) w[k] = DW'($urandom);
    send(w);
    repeat (6) tick();
    check_out("post-reset identity", w, 0);

    // Write and commit on the same edge; out-of-range row ignored.
    cfg_wr_en  = 1'b1;
    cfg_stage  = 3'd0;
    cfg_data   = 8'h01;
    cfg_commit = 1'b1;
    tick();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    for (int k = 0; k < N; k++) w[k] = DW'($urandom);
    e = w; e[0] = w[1]; e[1] = w[0];
    send(w);
    repeat (6) tick();
    check_out("write-through", e, 1);
    cfg_write(7, 8'hFF);
    commit();
    for (int k = 0; k < N; k++) w[k] = DW'($urandom);
    e = w; e[0] = w[1]; e[1] = w[0];
    send(w);
    repeat (6) tick();
    check_out("row7 ignored", e, 2);

    // Random traffic with random config activity and a back-to-back commit burst.
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < N; k++) i_port[k] = DW'($urandom);
      i_valid    = ($urandom_range(0, 9) < 7);
      cfg_wr_en  = ($urandom_range(0, 3) == 0) || (t >= 200 && t < 212);
      cfg_stage  = SIDX_W'($urandom_range(0, 7));
      cfg_data   = SW'($urandom);
      cfg_commit = ($urandom_range(0, 7) == 0) || (t >= 200 && t < 212);
      tick();
    end
    i_valid    = 1'b0;
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/benes_network_pipe.md
Name: benes_network_pipe

Overview:
- Parametrised, fully pipelined N×N rearrangeable Benes permutation network; successor to the fixed 16-port, 4-bit network_module.
- One register stage per switch column, plus a valid flag travelling with each word.
- Switch settings are double-buffered (shadow/active). A commit propagates down the pipeline as a wavefront, so every word is routed by exactly one configuration epoch.
- Sits between the SW-programmed config path and the data ports.

Parameters:
- N_PORTS, 16, port count; power of two, 4..64.
- DATA_W, 4, bits per port.
- ID_W, 4, width of config-epoch counter.
- (localparam) LOG2N = $clog2(N_PORTS); STAGES = 2*LOG2N-1; SW_PER_STAGE = N_PORTS/2; SIDX_W = $clog2(STAGES).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_port  in  DATA_W × [N_PORTS] (unpacked)  input words.
- i_valid  in  1  i_port valid this cycle.
- o_port  out  DATA_W × [N_PORTS]  permuted words.
- o_valid  out  1  o_port valid.
- o_cfg_id  out  ID_W  epoch that routed the current o_port word.
- cfg_wr_en  in  1  write shadow row.
- cfg_stage  in  SIDX_W  shadow row index.
- cfg_data  in  SW_PER_STAGE  switch bits for that row.
- cfg_commit  in  1  copy shadow into active (wavefront).

Behaviour:
- Switch model:
  - Stage s, switch j has inputs 2j and 2j+1.
  - Bit j = 0 is bar: out[2j]=in[2j], out[2j+1]=in[2j+1]. Bit j = 1 is cross: the two are swapped.
- Inter-stage wiring, with p the block-local index:
  - s→s+1 for s < LOG2N-1: inverse shuffle within blocks of M = N>>s. Even p→p/2; odd p→M/2+p/2.
  - s→s+1 for s ≥ LOG2N-1: perfect shuffle within blocks of M = 2^(s-LOG2N+3). p<M/2→2p; p≥M/2→2(p-M/2)+1.
- Pipeline:
  - Stage s output is registered. Latency is exactly STAGES cycles: a word sampled at edge t appears at o_port/o_valid after edge t+STAGES-1.
  - There is no backpressure.
  - Data registers of a stage load only when that stage's incoming valid=1; otherwise they hold. o_port therefore holds the last valid word.
- Config, shadow:
  - cfg_wr_en writes cfg_data into shadow[cfg_stage] at the edge.
  - cfg_stage ≥ STAGES: write ignored.
- Config, commit (edge e):
  - act[0] ← shadow, with any same-edge write included (write-through).
  - Epoch counter increments, wrapping mod 2^ID_W.
  - act[s] ← act[s-1] one edge later.
- Epoch consistency:
  - Words sampled at edge ≤ e use the old config in all stages and carry the old id.
  - Words sampled at edge > e use the new config everywhere and carry the new id.
  - The epoch id travels with each word to o_cfg_id.
- Back-to-back commits (every cycle) are legal; each wavefront stays independent.
- Reset (async assert, any time):
  - o_port=0, o_valid=0, o_cfg_id=0.
  - All stage data and valid regs cleared; all in-flight words discarded.
  - Shadow and all act[] cleared to 0, giving the identity permutation. Epoch counter = 0.
  - Deassertion is synchronous to clk (external synchroniser).
- All-bar configuration yields the identity. All-cross yields o_port[k]=i_port[k^(N/2)].

Test Plan:
- Reset, no config; i_port[k]=15-k with i_valid for 1 cycle -> 7 cycles later o_valid pulses 1 cycle, o_port[k]=15-k, o_cfg_id=0; o_port holds afterwards.
- Write rows 0..6 = 8'hFF, commit, i_port[k]=k -> o_port[k]=k^8, o_cfg_id=1.
- Only row 3 = 8'hFF, commit -> o_port[k]=i_port[k^8]. Only row 6 = 8'h01, commit -> o_port[0]=i_port[1], o_port[1]=i_port[0], rest identity.
- Continuous stream i_port[k]=k+n (word n); commit all-cross at the edge sampling word 5 -> words 0..5 identity with id 0, words 6.. XOR-8 with id 1, no mixed word.
- Assert rst_n low while 4 words are in flight -> o_valid/o_port/o_cfg_id 0 immediately, nothing emitted afterwards. The next word is routed as identity.
- cfg_wr_en + cfg_commit same cycle (row 0 = 8'h01) -> the next word swaps ports 0/1. cfg_stage=7 write -> no effect.
